// File: rtl/mc_control_fsm_v2.sv
// mc_control_fsm_v2: multi-cycle RV32I control FSM with memory handshake, illegal-op halt and retire counter
//  clk, reset_n (async, active-low)        clock / reset
//  op[6:0], funct3[2:0]                     instruction fields from IR
//  mem_ready                                memory access completes this cycle
//  mem_req                                  memory request (FETCH, MEMREAD, MEMWRITE)
//  PCUpdate Branch AddrSrc MemWrite IRWrite RegWrite   datapath strobes/selects
//  ResultSrc ALUOp ALUSrcA ALUSrcB [1:0]    datapath mux selects (ALUSrcA 11 = zero)
//  ImmSrc[2:0]                              immediate format from op
//  illegal                                  pulse on illegal instruction in DECODE
//  halted                                   high in HALT
//  retired_cnt[CNT_W-1:0]                   retired instruction count
//  state_o[3:0]                             current state
module mc_control_fsm_v2 #(
  parameter int CNT_W = 32,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PCUpdate,
  output logic             Branch,
  output logic             AddrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [3:0]       state_o
);
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_B = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
    EXECR = 4'd6, ALUWB = 4'd7, EXECI = 4'd8, JAL = 4'd9, BRANCH = 4'd10, LUI = 4'd11,
    AUIPC = 4'd12, JALR = 4'd13, HALT = 4'd15
  } state_t;
  state_t state, nxt, dec;
  logic mr, bad, retire;
  assign mr = MEM_HANDSHAKE ? mem_ready : 1'b1;
  always_comb begin
    bad = (op == OP_LW || op == OP_SW) ? funct3 != 3'b010 :
          (op == OP_B) ? (funct3 == 3'b010 || funct3 == 3'b011) :
          (op == OP_JALR) ? funct3 != 3'b000 :
          !(op == OP_R || op == OP_I || op == OP_JAL || op == OP_LUI || op == OP_AUIPC);
    dec = (op == OP_LW || op == OP_SW || op == OP_JALR) ? MEMADR :
          (op == OP_R) ? EXECR : (op == OP_I) ? EXECI : (op == OP_JAL) ? JAL :
          (op == OP_B) ? BRANCH : (op == OP_LUI) ? LUI : (op == OP_AUIPC) ? AUIPC : HALT;
    ImmSrc = (op == OP_SW) ? 3'b001 : (op == OP_B) ? 3'b010 : (op == OP_JAL) ? 3'b011 :
             (op == OP_LUI || op == OP_AUIPC) ? 3'b100 : 3'b000;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else state <= nxt;
  always_comb begin
    nxt = HALT;
    case (state)
      FETCH:    nxt = mr ? DECODE : FETCH;
      DECODE:   nxt = bad ? (HALT_ON_ILLEGAL ? HALT : FETCH) : dec;
      MEMADR:   nxt = (op == OP_LW) ? MEMREAD : (op == OP_SW) ? MEMWRITE : (op == OP_JALR) ? JALR : HALT;
      MEMREAD:  nxt = mr ? MEMWB : MEMREAD;
      MEMWRITE: nxt = mr ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL, JALR, LUI, AUIPC: nxt = ALUWB;
      MEMWB, ALUWB, BRANCH: nxt = FETCH;
      default:  nxt = HALT;
    endcase
  end
  assign retire = state == MEMWB || state == ALUWB || state == BRANCH || (state == MEMWRITE && mr);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) retired_cnt <= '0;
    else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
  always_comb begin
    {mem_req, PCUpdate, Branch, AddrSrc, MemWrite, IRWrite, RegWrite} = '0;
    ResultSrc = '0;
    ALUOp = '0;
    ALUSrcA = '0;
    ALUSrcB = '0;
    case (state)
      FETCH:    begin mem_req = 1'b1; IRWrite = mr; PCUpdate = mr; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
      DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      MEMREAD:  begin mem_req = 1'b1; AddrSrc = 1'b1; end
      MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      MEMWRITE: begin mem_req = 1'b1; AddrSrc = 1'b1; MemWrite = mr; end
      EXECR:    begin ALUSrcA = 2'b10; ALUOp = 2'b10; end
      EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUOp = 2'b10; end
      ALUWB:    RegWrite = 1'b1;
      JAL, JALR: begin PCUpdate = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
      BRANCH:   begin ALUSrcA = 2'b10; ALUOp = 2'b01; Branch = 1'b1; end
      LUI:      begin ALUSrcA = 2'b11; ALUSrcB = 2'b01; end
      AUIPC:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      default:  ;
    endcase
    if (!reset_n) {mem_req, PCUpdate, IRWrite, MemWrite, RegWrite} = '0;
  end
  assign illegal = reset_n && state == DECODE && bad;
  assign halted = state == HALT;
  assign state_o = state;
endmodule

// File: tb/tb_mc_control_fsm_v2.sv
// tb_mc_control_fsm_v2: scoreboard bench for two configurations of the multi-cycle control FSM
module tb_mc_control_fsm_v2;
  localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                         OP_I = 7'b0010011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                         OP_B = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam logic [3:0] S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_WB = 4, S_ST = 5, S_ER = 6,
                         S_AW = 7, S_EI = 8, S_JAL = 9, S_BR = 10, S_LUI = 11, S_AUI = 12,
                         S_JR = 13, S_H = 15;
  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        ill;
    logic        hlt;
    logic [2:0]  imm;
    logic [31:0] cnt;
  } rec_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic [1:0] rn = '0, mr = '0, ill, hlt;
  logic [1:0][6:0] op = '0;
  logic [1:0][2:0] f3 = '0, imm;
  logic [1:0][14:0] ctl;
  logic [1:0][3:0] st;
  logic [31:0] cnt0;
  logic [3:0] cnt1;
  rec_t q0[$], q1[$];
  int passed = 0, total = 0;
  logic [31:0] mcnt[2] = '{0, 0};
  int hs[2] = '{1, 0};
  logic [31:0] cmask[2] = '{32'hFFFF_FFFF, 32'h0000_000F};
  mc_control_fsm_v2 u0 (
    .clk(clk), .reset_n(rn[0]), .op(op[0]), .funct3(f3[0]), .mem_ready(mr[0]),
    .mem_req(ctl[0][14]), .PCUpdate(ctl[0][13]), .Branch(ctl[0][12]), .AddrSrc(ctl[0][11]),
    .MemWrite(ctl[0][10]), .IRWrite(ctl[0][9]), .RegWrite(ctl[0][8]), .ResultSrc(ctl[0][7:6]),
    .ALUOp(ctl[0][5:4]), .ALUSrcA(ctl[0][3:2]), .ALUSrcB(ctl[0][1:0]), .ImmSrc(imm[0]),
    .illegal(ill[0]), .halted(hlt[0]), .retired_cnt(cnt0), .state_o(st[0]));
  mc_control_fsm_v2 #(.CNT_W(4), .MEM_HANDSHAKE(1'b0), .HALT_ON_ILLEGAL(1'b0)) u1 (
    .clk(clk), .reset_n(rn[1]), .op(op[1]), .funct3(f3[1]), .mem_ready(mr[1]),
    .mem_req(ctl[1][14]), .PCUpdate(ctl[1][13]), .Branch(ctl[1][12]), .AddrSrc(ctl[1][11]),
    .MemWrite(ctl[1][10]), .IRWrite(ctl[1][9]), .RegWrite(ctl[1][8]), .ResultSrc(ctl[1][7:6]),
    .ALUOp(ctl[1][5:4]), .ALUSrcA(ctl[1][3:2]), .ALUSrcB(ctl[1][1:0]), .ImmSrc(imm[1]),
    .illegal(ill[1]), .halted(hlt[1]), .retired_cnt(cnt1), .state_o(st[1]));
  function automatic logic [14:0] mk(bit rq, bit pc, bit br, bit as, bit mw, bit iw, bit rw,
                                     logic [1:0] rs, logic [1:0] ao, logic [1:0] a, logic [1:0] b);
    return {rq, pc, br, as, mw, iw, rw, rs, ao, a, b};
  endfunction
  function automatic logic [14:0] exp_ctl(logic [3:0] s, bit m);
    case (s)
      S_F:          return mk(1, m, 0, 0, 0, m, 0, 2'b10, 2'b00, 2'b00, 2'b10);
      S_D, S_AUI:   return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b01);
      S_MA:         return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 2'b01);
      S_MR:         return mk(1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      S_WB:         return mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
      S_ST:         return mk(1, 0, 0, 1, m, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
      S_ER:         return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b00);
      S_EI:         return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 2'b01);
      S_AW:         return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
      S_JAL, S_JR:  return mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b10);
      S_BR:         return mk(0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
      S_LUI:        return mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 2'b01);
      default:      return '0;
    endcase
  endfunction
  function automatic bit legal(logic [6:0] o, logic [2:0] f);
    case (o)
      OP_LW, OP_SW: return f == 3'd2;
      OP_B:         return f != 3'd2 && f != 3'd3;
      OP_JALR:      return f == 3'd0;
      OP_R, OP_I, OP_JAL, OP_LUI, OP_AUIPC: return 1;
      default:      return 0;
    endcase
  endfunction
  function automatic logic [2:0] immf(logic [6:0] o);
    case (o)
      OP_SW:           return 3'b001;
      OP_B:            return 3'b010;
      OP_JAL:          return 3'b011;
      OP_LUI, OP_AUIPC: return 3'b100;
      default:         return 3'b000;
    endcase
  endfunction
  task automatic push(int d, rec_t r);
    if (d == 0) q0.push_back(r);
    else q1.push_back(r);
  endtask
  task automatic push_st(int d, logic [3:0] s, bit m, bit il);
    rec_t r;
    r.st = s; r.ctl = exp_ctl(s, m); r.ill = il; r.hlt = (s == S_H);
    r.imm = immf(op[d]); r.cnt = mcnt[d] & cmask[d];
    push(d, r);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic rst(int d);
    rec_t r;
    rn[d] = 0;
    mcnt[d] = 0;
    r.st = S_F; r.ctl = mk(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b10);
    r.ill = 0; r.hlt = 0; r.imm = immf(op[d]); r.cnt = 0;
    push(d, r);
    step;
    rn[d] = 1;
  endtask
  task automatic halt_cycles(int d, int n);
    repeat (n) begin
      op[d] = 7'($urandom);
      mr[d] = 1'($urandom);
      push_st(d, S_H, 0, 0);
      step;
    end
  endtask
  // Expected state walk for one instruction, built from the instruction class
  task automatic run(int d, logic [6:0] o, logic [2:0] f, int hold, bit abort);
    logic [3:0] path[$];
    bit lg, done, m, e;
    int h;
    lg = legal(o, f);
    h = hold;
    op[d] = o;
    f3[d] = f;
    path.push_back(S_F);
    path.push_back(S_D);
    if (lg)
      case (o)
        OP_LW:    begin path.push_back(S_MA); path.push_back(S_MR); path.push_back(S_WB); end
        OP_SW:    begin path.push_back(S_MA); path.push_back(S_ST); end
        OP_R:     begin path.push_back(S_ER); path.push_back(S_AW); end
        OP_I:     begin path.push_back(S_EI); path.push_back(S_AW); end
        OP_JAL:   begin path.push_back(S_JAL); path.push_back(S_AW); end
        OP_JALR:  begin path.push_back(S_MA); path.push_back(S_JR); path.push_back(S_AW); end
        OP_B:     path.push_back(S_BR);
        OP_LUI:   begin path.push_back(S_LUI); path.push_back(S_AW); end
        default:  begin path.push_back(S_AUI); path.push_back(S_AW); end
      endcase
    foreach (path[i]) begin
      done = 0;
      while (!done) begin
        if (path[i] == S_MR && h > 0) begin
          m = 0;
          h--;
        end else m = $urandom_range(0, 2) != 0;
        e = (hs[d] != 0) ? m : 1'b1;
        mr[d] = m;
        push_st(d, path[i], e, path[i] == S_D && !lg);
        step;
        if (abort && path[i] == S_MR) return;
        done = !(path[i] inside {S_F, S_MR, S_ST}) || e;
      end
    end
    if (lg) mcnt[d] = mcnt[d] + 1;
  endtask
  task automatic run_rand(int d, bit allow_bad);
    logic [6:0] ops[9];
    logic [6:0] o;
    logic [2:0] f;
    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_JALR, OP_B, OP_LUI, OP_AUIPC};
    o = ops[$urandom_range(0, 8)];
    f = 3'($urandom);
    if (allow_bad && $urandom_range(0, 4) == 0) o = 7'($urandom);
    else while (!legal(o, f)) f = 3'($urandom);
    run(d, o, f, 0, 0);
  endtask
  task automatic chk(int d, rec_t e, logic [3:0] as, logic [14:0] ac, bit ai, bit ah,
                     logic [2:0] ami, logic [31:0] acnt);
    total++;
    if ({as, ac, ai, ah, ami} === {e.st, e.ctl, e.ill, e.hlt, e.imm}) passed++;
    else $display("FAIL dut%0d outputs: got st=%0d ctl=%h ill=%b halted=%b imm=%0d, expected st=%0d ctl=%h ill=%b halted=%b imm=%0d",
                  d, as, ac, ai, ah, ami, e.st, e.ctl, e.ill, e.hlt, e.imm);
    total++;
    if (acnt === e.cnt) passed++;
    else $display("FAIL dut%0d retired_cnt: got %0d expected %0d (st=%0d)", d, acnt, e.cnt, e.st);
  endtask
  always @(negedge clk) begin
    if (q0.size() > 0) chk(0, q0.pop_front(), st[0], ctl[0], ill[0], hlt[0], imm[0], cnt0);
    if (q1.size() > 0) chk(1, q1.pop_front(), st[1], ctl[1], ill[1], hlt[1], imm[1], {28'd0, cnt1});
  end
  initial begin
    repeat (2) step;
    rst(0);
    run(0, OP_R, 3'd0, 0, 0);
    run(0, OP_LW, 3'd2, 3, 0);
    run(0, OP_JALR, 3'd0, 0, 0);
    run(0, OP_SW, 3'd2, 2, 0);
    run(0, OP_B, 3'd1, 0, 0);
    run(0, OP_LUI, 3'd5, 0, 0);
    run(0, OP_AUIPC, 3'd7, 0, 0);
    run(0, OP_JAL, 3'd3, 0, 0);
    repeat (40) run_rand(0, 0);
    run(0, OP_LW, 3'd2, 5, 1);
    rst(0);
    run(0, OP_I, 3'd4, 0, 0);
    run(0, 7'h7F, 3'd0, 0, 0);
    halt_cycles(0, 4);
    rst(0);
    run(0, OP_LW, 3'd0, 0, 0);
    halt_cycles(0, 2);
    rst(0);
    run(0, OP_B, 3'd3, 0, 0);
    halt_cycles(0, 2);
    rst(0);
    run(0, OP_JALR, 3'd1, 0, 0);
    halt_cycles(0, 2);
    rn[0] = 0;
    rst(1);
    run(1, OP_SW, 3'd0, 0, 0);
    repeat (17) run(1, OP_I, 3'($urandom), 0, 0);
    run(1, OP_LW, 3'd2, 3, 0);
    run(1, OP_SW, 3'd2, 3, 0);
    repeat (40) run_rand(1, 1);
    run(1, OP_LW, 3'd2, 0, 1);
    rst(1);
    run(1, OP_R, 3'd0, 0, 0);
    rn[1] = 0;
    repeat (3) step;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
